// File: rtl/pwconv_requant_pack.sv
// ============================================================================
// pwconv_requant_pack
// ----------------------------------------------------------------------------
// Downstream stage of the pointwise-convolution PE. Each finished accumulator
// value goes through a rounding arithmetic right shift and is then clamped to
// OUT_W bits (stage 1, registered). PACK clamped pixels are collected into one
// word (stage 2). Finished words are held in a FIFO that feeds the
// feature-map write path through a valid/ready handshake. The PE cannot be
// stalled, so the block flags almost-full and a sticky overflow instead.
//
// Optional feature (compile-time macro):
//   PWCONV_REQUANT_RELU_EN  defined   : ReLU, lanes in 0 .. 2^(OUT_W-1)-1
//                           undefined : signed saturation, lanes in
//                                       -2^(OUT_W-1) .. 2^(OUT_W-1)-1
//
// Ports:
//   clk            clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   acc_valid_i    acc_i carries a finished pixel this cycle
//   acc_i          signed accumulator result from the PE
//   shift_i        requant right-shift amount (0..ACC_W-1), quasi-static
//   flush_i        close the partial word: zero-pad and push
//   out_ready_i    consumer accepts out_data_o
//   out_valid_o    FIFO non-empty
//   out_data_o     packed head word, lane 0 in the LSBs
//   almost_full_o  FIFO count >= FIFO_DEPTH-1
//   ovf_o          sticky: a word was dropped because the FIFO was full
// ============================================================================
module pwconv_requant_pack #(
  parameter int DATA_W     = 8,
  parameter int FILTER_W   = 8,
  parameter int ACC_W      = DATA_W + FILTER_W + 6,
  parameter int OUT_W      = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_valid_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic        [4:0]       shift_i,
  input  logic                    flush_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic [OUT_W*PACK-1:0]   out_data_o,
  output logic                    almost_full_o,
  output logic                    ovf_o
);

  localparam int LANE_W = $clog2(PACK);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int WORD_W = OUT_W * PACK;

  // Clamp bounds expressed at the internal ACC_W+1 width.
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  // --------------------------------------------------------------------------
  // Stage 1: rounding shift + clamp
  // --------------------------------------------------------------------------
  // One guard bit above ACC_W keeps acc + half-LSB from wrapping.
  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;
  logic [OUT_W-1:0]      pix_d;

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_ext = {acc_i[ACC_W-1], acc_i};
    rnd     = '0;
    if (shift_i != 5'd0) rnd = (ACC_W+1)'(1) << (shift_i - 5'd1);
    sum     = acc_ext + rnd;
    shifted = sum >>> shift_i;
    pix_d   = shifted[OUT_W-1:0];
`ifdef PWCONV_REQUANT_RELU_EN
    if (shifted[ACC_W])             pix_d = '0;
    else if (shifted > SAT_MAX)     pix_d = SAT_MAX[OUT_W-1:0];
`else
    if (shifted < SAT_MIN)          pix_d = SAT_MIN[OUT_W-1:0];
    else if (shifted > SAT_MAX)     pix_d = SAT_MAX[OUT_W-1:0];
`endif
  end

  logic             s1_valid;
  logic [OUT_W-1:0] s1_pix;
  logic             flush_d;   // flush_i delayed to line up with s1_pix

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      flush_d  <= 1'b0;
    end else begin
      s1_valid <= acc_valid_i;
      s1_pix   <= pix_d;
      flush_d  <= flush_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: lane packer
  // --------------------------------------------------------------------------
  logic [LANE_W-1:0]           lane;
  logic [PACK-1:0][OUT_W-1:0]  lanes_q;
  logic [PACK-1:0][OUT_W-1:0]  lanes_n;
  logic                        push;

  // The word being pushed includes the pixel arriving this cycle, so a
  // coincident flush sees that pixel first. lanes_q is cleared after every
  // push, which makes unfilled lanes of a flushed word read zero.
  always_comb begin
    lanes_n = lanes_q;
    if (s1_valid) lanes_n[lane] = s1_pix;
    push = (s1_valid && (lane == LANE_W'(PACK - 1))) ||
           (flush_d && (s1_valid || (lane != '0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane    <= '0;
      lanes_q <= '0;
    end else if (push) begin
      lane    <= '0;
      lanes_q <= '0;
    end else if (s1_valid) begin
      lane    <= lane + LANE_W'(1);
      lanes_q <= lanes_n;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              pop;
  logic              wr_en;

  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && out_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  // NOTE: storage has no reset; nothing reads a slot before it is written
  // because the output is gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= lanes_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!wr_en && pop) count <= count - (PTR_W+1)'(1);
      if (push && !wr_en)     ovf_o <= 1'b1;
    end
  end

  assign out_valid_o   = !empty;
  assign out_data_o    = empty ? '0 : mem[rd_ptr];
  assign almost_full_o = (count >= (PTR_W+1)'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_pwconv_requant_pack.sv
// ============================================================================
// tb_pwconv_requant_pack
// ----------------------------------------------------------------------------
// Directed bench for pwconv_requant_pack. A table of four-pixel words with
// hand-computed packed results is replayed first, then hand-written
// sequences cover flush, FIFO overflow, push/pop on a full FIFO and reset in
// the middle of a word. Expected lane values follow the build's
// PWCONV_REQUANT_RELU_EN setting. Inputs change and outputs are sampled on
// the falling clock edge.
// ============================================================================
module tb_pwconv_requant_pack;

  localparam int ACC_W  = 22;
  localparam int WORD_W = 32;

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef struct {
    logic [4:0]        shift;
    acc_t              px [4];
    logic [WORD_W-1:0] exp_word;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              acc_valid;
  acc_t              acc;
  logic [4:0]        shift;
  logic              flush;
  logic              out_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              almost_full;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  vec_t vecs [5];

  always #5 clk = ~clk;

  pwconv_requant_pack dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .acc_valid_i   (acc_valid),
    .acc_i         (acc),
    .shift_i       (shift),
    .flush_i       (flush),
    .out_ready_i   (out_ready),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .almost_full_o (almost_full),
    .ovf_o         (ovf)
  );

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_vec(input int idx, input int sh, input int a, input int b,
                         input int c, input int d, input logic [WORD_W-1:0] e);
    vecs[idx].shift    = 5'(sh);
    vecs[idx].px[0]    = acc_t'(a);
    vecs[idx].px[1]    = acc_t'(b);
    vecs[idx].px[2]    = acc_t'(c);
    vecs[idx].px[3]    = acc_t'(d);
    vecs[idx].exp_word = e;
  endtask

  // One pixel for one cycle; consecutive calls give back-to-back pixels.
  task automatic drive_px(input int v, input logic fl);
    acc_valid = 1'b1;
    acc       = acc_t'(v);
    flush     = fl;
    tick();
    acc_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Four pixels, then one idle cycle; returns once the word is in the FIFO.
  // With pop_at_push the consumer takes the head in the push cycle.
  task automatic send_word(input int sh, input int a, input int b, input int c,
                           input int d, input logic pop_at_push);
    shift = 5'(sh);
    drive_px(a, 1'b0);
    drive_px(b, 1'b0);
    drive_px(c, 1'b0);
    drive_px(d, 1'b0);
    out_ready = pop_at_push;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [WORD_W-1:0] rep4(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {b, b, b, b};
  endfunction

  initial begin
    rst_n     = 1'b0;
    acc_valid = 1'b0;
    acc       = '0;
    shift     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

`ifdef PWCONV_REQUANT_RELU_EN
    set_vec(0,  4,    100,    -50,    2047,     24, 32'h027F0006);
    set_vec(1,  0,     -1,   -300,     300,      5, 32'h057F0000);
    set_vec(2,  2,      5,      6,       7,     -7, 32'h00020201);
    set_vec(3, 21, 2097151, -2097152,    0, 1048576, 32'h01000001);
    set_vec(4,  8, -32768,  32767,   32511, -33024, 32'h007F7F00);
`else
    set_vec(0,  4,    100,    -50,    2047,     24, 32'h027FFD06);
    set_vec(1,  0,     -1,   -300,     300,      5, 32'h057F80FF);
    set_vec(2,  2,      5,      6,       7,     -7, 32'hFE020201);
    set_vec(3, 21, 2097151, -2097152,    0, 1048576, 32'h0100FF01);
    set_vec(4,  8, -32768,  32767,   32511, -33024, 32'h807F7F80);
`endif

    tick();
    tick();
    check("rst_valid",       32'(out_valid),   32'd0);
    check("rst_data",        out_data,         32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_ovf",         32'(ovf),         32'd0);
    rst_n = 1'b1;
    tick();

    // ---- table: requant/clamp/pack, latency, hold while not ready ----
    for (int i = 0; i < 5; i++) begin
      shift = vecs[i].shift;
      for (int j = 0; j < 4; j++) drive_px(int'(vecs[i].px[j]), 1'b0);
      check($sformatf("vec%0d_valid_t+1", i), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("vec%0d_valid_t+2", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", i),      out_data,       vecs[i].exp_word);
      tick();
      check($sformatf("vec%0d_hold", i),      out_data,       vecs[i].exp_word);
      pop_one();
      check($sformatf("vec%0d_drained", i),   32'(out_valid), 32'd0);
    end

    // ---- flush after a partial word ----
    shift = 5'd0;
    drive_px(16, 1'b0);
    drive_px(32, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_early", 32'(out_valid), 32'd0);
    tick();
    check("flush_valid", 32'(out_valid), 32'd1);
    check("flush_data",  out_data,       32'h00002010);
    pop_one();

    // ---- flush coincident with the last pixel ----
    drive_px(16, 1'b0);
    drive_px(32, 1'b1);
    check("flush_coinc_early", 32'(out_valid), 32'd0);
    tick();
    check("flush_coinc_valid", 32'(out_valid), 32'd1);
    check("flush_coinc_data",  out_data,       32'h00002010);
    pop_one();

    // ---- flush with an empty word: nothing pushed ----
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    check("flush_empty", 32'(out_valid), 32'd0);

    // ---- overflow: five words with the consumer stalled ----
    for (int k = 1; k <= 5; k++) begin
      send_word(0, k, k, k, k, 1'b0);
      check($sformatf("ovf_fill%0d_af", k),  32'(almost_full), (k >= 3) ? 32'd1 : 32'd0);
      check($sformatf("ovf_fill%0d_ovf", k), 32'(ovf),         (k == 5) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_drain%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("ovf_drain%0d_data", k),  out_data,       rep4(k));
      pop_one();
      check($sformatf("ovf_drain%0d_sticky", k), 32'(ovf),      32'd1);
    end
    check("ovf_empty", 32'(out_valid), 32'd0);

    // ---- reset clears the sticky flag ----
    rst_n = 1'b0;
    #1;
    check("rst2_ovf",   32'(ovf),       32'd0);
    check("rst2_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- full FIFO, push and pop in the same cycle ----
    for (int k = 1; k <= 4; k++) send_word(0, k, k, k, k, 1'b0);
    check("full_af", 32'(almost_full), 32'd1);
    send_word(0, 5, 5, 5, 5, 1'b1);
    check("full_pp_ovf", 32'(ovf),         32'd0);
    check("full_pp_af",  32'(almost_full), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("full_pp_drain%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("full_pp_drain%0d_data", k),  out_data,       rep4(k));
      pop_one();
    end
    check("full_pp_empty", 32'(out_valid), 32'd0);

    // ---- reset in the middle of a word ----
    send_word(0, 7, 7, 7, 7, 1'b0);
    drive_px(9, 1'b0);
    drive_px(9, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid),   32'd0);
    check("midrst_data",  out_data,         32'd0);
    check("midrst_af",    32'(almost_full), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_after_valid", 32'(out_valid), 32'd0);
    send_word(0, 1, 2, 3, 4, 1'b0);
    check("midrst_word_valid", 32'(out_valid), 32'd1);
    check("midrst_word_data",  out_data,       32'h04030201);
    pop_one();
    check("midrst_word_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwconv_requant_pack.md
Name: pwconv_requant_pack

Overview:
- Downstream stage of the pointwise-convolution PE. It consumes the PE's signed accumulator result and requantizes it with a rounding right shift, then ReLU/saturation, down to OUT_W bits.
- It packs PACK requantized pixels into one output word and buffers the words in a small FIFO.
- The FIFO drives the feature-map write path with a valid/ready handshake.
- The PE has no backpressure, so this block reports almost-full and overflow instead.

Parameters:
DATA_W, 8, PE pixel width
FILTER_W, 8, PE weight width
ACC_W, DATA_W+FILTER_W+6 (=22), accumulator input width
OUT_W, 8, requantized pixel width
PACK, 4, pixels per output word (power of 2)
FIFO_DEPTH, 4, output FIFO depth in words (power of 2)

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
acc_valid_i  input  1  acc_i carries a finished pixel this cycle
acc_i  input  ACC_W  signed accumulator result from PE
shift_i  input  5  requant right-shift amount (0..ACC_W-1), quasi-static
flush_i  input  1  close partial word: zero-pad and push
out_ready_i  input  1  consumer accepts out_data_o
out_valid_o  output  1  FIFO non-empty
out_data_o  output  OUT_W*PACK  packed word, lane 0 in LSBs
almost_full_o  output  1  FIFO count >= FIFO_DEPTH-1
ovf_o  output  1  sticky: word dropped because FIFO full

Behaviour:
- Reset: rst_n is asynchronous and active-low. Reset clears all registers, the lane counter, the FIFO pointers and count, and ovf_o. All outputs read 0 during and after reset.
- Reset mid-operation: any partial word is discarded.
- Stage 1 (registered, 1 cycle):
  - r = (acc_i + (1<<(shift_i-1))) >>> shift_i, computed at ACC_W+1 bits; when shift_i=0, r = acc_i.
  - ReLU: r<0 gives 0.
  - Saturate: r>2^(OUT_W-1)-1 gives 127.
  - The result and a valid bit are registered.
- Stage 2 packer:
  - Lane counter 0..PACK-1; a valid pixel is written to the current lane.
  - When the counter reaches PACK-1, the word is pushed and the counter wraps to 0.
  - flush_i is aligned through a 1-cycle delay so it acts in stage 2. When it acts with lanes>0, the word is pushed with unfilled lanes=0 and the counter returns to 0.
  - flush coincident with a valid pixel: the pixel is included first, then the push.
  - flush with an empty word: no push.
- Latency: a word completes at t+1 after the acc_valid_i of its last lane at cycle t. It is written to the FIFO at t+2, and out_valid_o=1 at t+2 if the FIFO was empty.
- Back-to-back valid pixels every cycle are supported.
- FIFO:
  - Pop when out_valid_o & out_ready_i.
  - out_data_o shows the head word and is stable while valid & !ready.
  - Push+pop in the same cycle when full: both accepted, count unchanged, no overflow.
  - Push when full without pop: the word is dropped and ovf_o=1 until reset.
  - Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.

Optional Feature:
- Macro PWCONV_REQUANT_RELU_EN.
- Defined: ReLU applied as above; output range 0..2^(OUT_W-1)-1.
- Undefined: no ReLU; signed saturation to [-2^(OUT_W-1), 2^(OUT_W-1)-1], two's-complement lanes.

Test Plan:
- RELU_EN defined, shift_i=4, pixels 100, -50, 2047, 24 back-to-back -> one word 32'h027F0006 (6, 0, 127 sat, 2), out_valid_o 2 cycles after the 4th pixel.
- RELU_EN undefined, shift_i=0, pixels -1, -300, 300, 5 -> 32'h057F80FF.
- shift_i=0, pixels 16, 32, then flush_i -> 32'h00002010. A second flush with empty word -> no push.
- out_ready_i=0, 5 full words pushed -> almost_full_o after 3rd, ovf_o after 5th. Drain returns words 1-4 in order and ovf_o stays 1.
- FIFO full, push cycle with out_ready_i=1 -> count stays 4, ovf_o stays 0, pushed word appears last.
- 2 pixels loaded, rst_n low 1 cycle mid-stream -> outputs 0, FIFO empty. The next 4 pixels form a word starting at lane 0.
